// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multdiv operation sequencer.
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int unsigned MULT_CYCLES_DEF = 32;
    localparam int unsigned DIV_CYCLES_DEF  = 33;

    // Counter width able to hold the largest step index of either operation.
    function automatic int unsigned step_width(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b);
    endfunction

endpackage

// File: rtl/multdiv_step_counter.sv
// Iteration index counter: clear has priority over increment.
module multdiv_step_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences multi-cycle MULT/DIV operations: step index, busy, op tag and
// registered result-ready / hold pulses, with restart and early completion.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = step_width(MULT_CYCLES, DIV_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             early_done,
    output logic             busy,
    output logic             op_div,
    output logic [CNT_W-1:0] step,
    output logic             data_resultRDY,
    output logic             data_resultRDY_hold
);

    // Step value in the last RUN cycle; the following edge enters DONE.
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 2);

    state_t           r_state;
    logic             r_op_div;
    logic             r_busy;
    logic             r_rdy;
    logic             r_hold;
    logic             w_start;
    logic             w_run;
    logic [CNT_W-1:0] w_step;
    logic [CNT_W-1:0] w_last;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_run   = (r_state == ST_RUN);
    assign w_last  = r_op_div ? DIV_LAST : MULT_LAST;

    multdiv_step_counter #(
        .CNT_W (CNT_W)
    ) u_step_counter (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_start),
        .i_en    (w_run),
        .o_count (w_step)
    );

    // Output flags are registered alongside the state they decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_op_div <= 1'b0;
            r_busy   <= 1'b0;
            r_rdy    <= 1'b0;
            r_hold   <= 1'b0;
        end else begin
            r_busy <= 1'b0;
            r_rdy  <= 1'b0;
            r_hold <= 1'b0;
            if (w_start) begin
                r_state  <= ST_RUN;
                r_op_div <= ctrl_DIV;
                r_busy   <= 1'b1;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (early_done || (w_step == w_last)) begin
                            r_state <= ST_DONE;
                            r_rdy   <= 1'b1;
                        end else begin
                            r_busy <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_HOLD;
                        r_hold  <= 1'b1;
                    end
                    ST_HOLD: begin
                        r_state <= ST_IDLE;
                    end
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy                = r_busy;
    assign op_div              = r_op_div;
    assign step                = w_step;
    assign data_resultRDY      = r_rdy;
    assign data_resultRDY_hold = r_hold;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: timeline model plus ready-pulse scoreboard.
module tb_multdiv_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       ctrl_MULT, ctrl_DIV, early_done;
    logic       busy, op_div, rdy, hold;
    logic [5:0] step;

    logic       b_div;
    logic       b_busy, b_op_div, b_rdy, b_hold;
    logic [5:0] b_step;

    int n_assert = 0;
    int n_fail   = 0;
    int t        = 0;

    // Timeline of the most recent operation as seen by the bench.
    int   m_t0, m_end;
    logic m_op, m_valid;

    typedef struct {
        int   cyc;
        logic op;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    multdiv_sequencer u_dut (
        .clk                 (clk),
        .reset               (reset),
        .ctrl_MULT           (ctrl_MULT),
        .ctrl_DIV            (ctrl_DIV),
        .early_done          (early_done),
        .busy                (busy),
        .op_div              (op_div),
        .step                (step),
        .data_resultRDY      (rdy),
        .data_resultRDY_hold (hold)
    );

    multdiv_sequencer #(
        .MULT_CYCLES (32),
        .DIV_CYCLES  (4),
        .CNT_W       (6)
    ) u_dut4 (
        .clk                 (clk),
        .reset               (reset),
        .ctrl_MULT           (1'b0),
        .ctrl_DIV            (b_div),
        .early_done          (1'b0),
        .busy                (b_busy),
        .op_div              (b_op_div),
        .step                (b_step),
        .data_resultRDY      (b_rdy),
        .data_resultRDY_hold (b_hold)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic check_cycle();
        int   exp_step;
        exp_t e;
        exp_step = 0;
        if (m_valid) exp_step = ((t < m_end) ? t : m_end) - m_t0 - 1;
        chk("busy", 32'(busy), 32'(m_valid && t > m_t0 && t < m_end));
        chk("rdy",  32'(rdy),  32'(m_valid && t == m_end));
        chk("hold", 32'(hold), 32'(m_valid && t == m_end + 1));
        chk("step", 32'(step), 32'(exp_step));
        chk("op_div", 32'(op_div), 32'(m_op));
        if (rdy === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rdy_unexpected", 32'(rdy), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("sb_rdy_cycle", 32'(t), 32'(e.cyc));
                chk("sb_rdy_op", 32'(op_div), 32'(e.op));
            end
        end
        while (sb.size() > 0 && sb[0].cyc < t) begin
            chk("sb_rdy_missing", 32'(t), 32'(sb[0].cyc));
            void'(sb.pop_front());
        end
    endtask

    // Check this cycle's outputs, then drive its inputs and advance the model.
    task automatic cycle(input logic m, input logic d, input logic e);
        @(negedge clk);
        check_cycle();
        ctrl_MULT  = m;
        ctrl_DIV   = d;
        early_done = e;
        if (e && m_valid && t > m_t0 && t < m_end) begin
            m_end = t + 1;
            if (sb.size() > 0) sb[sb.size()-1].cyc = m_end;
        end
        if (m || d) begin
            if (sb.size() > 0 && sb[sb.size()-1].cyc > t) void'(sb.pop_back());
            m_valid = 1'b1;
            m_op    = d;
            m_t0    = t;
            m_end   = t + (d ? 33 : 32);
            sb.push_back('{cyc: m_end, op: d});
        end
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic sb_drained(input string tag);
        chk(tag, 32'(sb.size()), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", t);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; early_done = 1'b0; b_div = 1'b0;
        m_valid = 1'b0; m_op = 1'b0; m_t0 = 0; m_end = 0;

        // Reset held, then released and idle: everything stays low.
        idle(3);
        reset = 1'b0;
        idle(40);

        // Default MULT: ready 32 cycles after start.
        cycle(1'b1, 1'b0, 1'b0);
        idle(39);
        sb_drained("sb_mult");

        // Default DIV: ready 33 cycles after start.
        cycle(1'b0, 1'b1, 1'b0);
        idle(39);
        sb_drained("sb_div");

        // Short-latency DIV instance: ready in cycle 4, hold in cycle 5.
        cycle(1'b0, 1'b0, 1'b0);
        b_div = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, 1'b0, 1'b0);
            b_div = 1'b0;
            chk("div4_busy", 32'(b_busy), 32'(k <= 3));
            chk("div4_rdy",  32'(b_rdy),  32'(k == 4));
            chk("div4_hold", 32'(b_hold), 32'(k == 5));
            chk("div4_step", 32'(b_step), 32'((k <= 4) ? k - 1 : 3));
            chk("div4_op",   32'(b_op_div), 32'(1));
        end

        // DIV with early completion in cycle 5.
        cycle(1'b0, 1'b1, 1'b0);
        idle(4);
        cycle(1'b0, 1'b0, 1'b1);
        idle(35);
        sb_drained("sb_early");

        // MULT restarted as DIV in cycle 10, then simultaneous start.
        cycle(1'b1, 1'b0, 1'b0);
        idle(9);
        cycle(1'b0, 1'b1, 1'b0);
        idle(40);
        sb_drained("sb_restart");
        cycle(1'b1, 1'b1, 1'b0);
        idle(38);
        sb_drained("sb_both");

        // Start held for three cycles: completion counts from the last one.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        idle(36);
        sb_drained("sb_held");

        // Async reset in the middle of a MULT: outputs clear at once, no pulse.
        cycle(1'b1, 1'b0, 1'b0);
        idle(15);
        #1 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_rdy",  32'(rdy),  32'(0));
        chk("arst_hold", 32'(hold), 32'(0));
        chk("arst_step", 32'(step), 32'(0));
        chk("arst_op",   32'(op_div), 32'(0));
        m_valid = 1'b0; m_op = 1'b0;
        sb.delete();
        #1 reset = 1'b0;
        idle(40);
        sb_drained("sb_reset");

        // Restart on the ready cycle: no hold pulse, next ready 32 later.
        cycle(1'b1, 1'b0, 1'b0);
        idle(31);
        cycle(1'b1, 1'b0, 1'b0);
        idle(40);
        sb_drained("sb_ready_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
